// File: rtl/hw_accel_pkg.sv
// Shared sizing helpers and defaults for the stream buffer and its RAM.
// Pointer width, word-counter width and the last-tag bit position all derive from here.
package hw_accel_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_FRAME_WORDS = 2304;
    localparam int DEFAULT_FIFO_DEPTH  = 512;

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int wcntWidth(input int frameWords);
        return (frameWords > 1) ? $clog2(frameWords) : 1;
    endfunction

    // Each entry is {last_tag, data}, so the tag sits just above the data bits.
    function automatic int lastBit(input int dataWidth);
        return dataWidth;
    endfunction

endpackage

// File: rtl/hw_accel_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port, shaped for block-RAM inference.
module hw_accel_sdp_ram
    import hw_accel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_DATA_WIDTH + 1,
    parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_W = ptrWidth(DEFAULT_FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]  wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [WIDTH-1:0]  rdData_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // No reset on the array or read register so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/hw_accel_stream_buffer.sv
// Frame-aware stream buffer between the pixel packer and the DMA, with a registered output stage.
// Optional statistics ports (frame_count, drop_count) are enabled by HW_ACCEL_STREAM_BUFFER_STATS_EN.
module hw_accel_stream_buffer
    import hw_accel_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  frame_done
`ifdef HW_ACCEL_STREAM_BUFFER_STATS_EN
   ,output logic [15:0]           frame_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int PTR_W    = ptrWidth(FIFO_DEPTH);
    localparam int WCNT_W   = wcntWidth(FRAME_WORDS);
    localparam int LAST_BIT = lastBit(DATA_WIDTH);
    localparam int ENTRY_W  = LAST_BIT + 1;
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(FRAME_WORDS - 1);

    logic [PTR_W:0]          wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, cnt_q, cnt_d;
    logic [WCNT_W-1:0]       wordCnt_q, wordCnt_d;
    logic                    ramValid_q, ramValid_d;
    logic                    outValid_q, outValid_d, outLast_q, outLast_d;
    logic [DATA_WIDTH-1:0]   outData_q, outData_d;
    logic                    overflow_q, overflow_d, frameDone_q, frameDone_d;
    logic [ENTRY_W-1:0]      wrEntry, rdEntry;
    logic                    wrEn, drop, rdEn, xfer, loadOut;

    hw_accel_sdp_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .wrEn_i   (wrEn),
        .wrAddr_i (wrPtr_q[PTR_W-1:0]),
        .wrData_i (wrEntry),
        .rdEn_i   (rdEn),
        .rdAddr_i (rdPtr_q[PTR_W-1:0]),
        .rdData_o (rdEntry)
    );

    // cnt counts every word not yet accepted downstream, including those in the RAM read
    // register and the output stage, so admission is limited to FIFO_DEPTH words in total.
    always_comb begin
        wrEn       = pixel_in_valid && (cnt_q != FULL_COUNT);
        drop       = pixel_in_valid && (cnt_q == FULL_COUNT);
        xfer       = outValid_q && out_ready;
        loadOut    = ramValid_q && (!outValid_q || out_ready);
        rdEn       = (rdPtr_q != wrPtr_q) && (!ramValid_q || loadOut);
        wrEntry    = {(wordCnt_q == LAST_WORD), pixel_in};

        wrPtr_d    = wrEn ? wrPtr_q + (PTR_W+1)'(1) : wrPtr_q;
        rdPtr_d    = rdEn ? rdPtr_q + (PTR_W+1)'(1) : rdPtr_q;
        cnt_d      = cnt_q + (PTR_W+1)'(wrEn) - (PTR_W+1)'(xfer);
        ramValid_d = rdEn ? 1'b1 : (loadOut ? 1'b0 : ramValid_q);

        wordCnt_d  = wordCnt_q;
        if (pixel_in_valid) begin
            wordCnt_d = (wordCnt_q == LAST_WORD) ? '0 : wordCnt_q + WCNT_W'(1);
        end

        outValid_d = outValid_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        if (loadOut) begin
            outValid_d = 1'b1;
            outData_d  = rdEntry[DATA_WIDTH-1:0];
            outLast_d  = rdEntry[LAST_BIT];
        end else if (xfer) begin
            outValid_d = 1'b0;
        end

        frameDone_d = xfer && outLast_q;
        overflow_d  = overflow_clr ? 1'b0 : (drop ? 1'b1 : overflow_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            cnt_q       <= '0;
            wordCnt_q   <= '0;
            ramValid_q  <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outLast_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            cnt_q       <= cnt_d;
            wordCnt_q   <= wordCnt_d;
            ramValid_q  <= ramValid_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outLast_q   <= outLast_d;
            overflow_q  <= overflow_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign out_data   = outData_q;
    assign out_valid  = outValid_q;
    assign out_last   = outLast_q;
    assign overflow   = overflow_q;
    assign frame_done = frameDone_q;

`ifdef HW_ACCEL_STREAM_BUFFER_STATS_EN
    logic [15:0] frameCount_q, frameCount_d, dropCount_q, dropCount_d;

    // frame_count wraps naturally; drop_count sticks at its maximum.
    always_comb begin
        frameCount_d = frameDone_q ? frameCount_q + 16'd1 : frameCount_q;
        dropCount_d  = (drop && (dropCount_q != 16'hFFFF)) ? dropCount_q + 16'd1 : dropCount_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frameCount_q <= '0;
            dropCount_q  <= '0;
        end else begin
            frameCount_q <= frameCount_d;
            dropCount_q  <= dropCount_d;
        end
    end

    assign frame_count = frameCount_q;
    assign drop_count  = dropCount_q;
`endif

endmodule

// File: tb/tb_hw_accel_stream_buffer.sv
// Directed self-checking bench for hw_accel_stream_buffer (default parameters).
// Inputs change 2 time units after each rising edge; outputs are observed on the falling edge.
module tb_hw_accel_stream_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pixel_in = '0;
    logic        pixel_in_valid = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic        frame_done;
`ifdef HW_ACCEL_STREAM_BUFFER_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] drop_count;
`endif

    int          totalChecks = 0;
    int          badChecks = 0;
    int          frameDoneCnt = 0;
    logic [32:0] expQ [$];

    always #5 clk = ~clk;

    hw_accel_stream_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr),
        .frame_done     (frame_done)
`ifdef HW_ACCEL_STREAM_BUFFER_STATS_EN
       ,.frame_count    (frame_count),
        .drop_count     (drop_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic c);
        @(posedge clk);
        #2;
        pixel_in_valid = v;
        pixel_in       = d;
        out_ready      = r;
        overflow_clr   = c;
    endtask

    task automatic applyReset(input string tag);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        expQ.delete();
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        frameDoneCnt = 0;
    endtask

    // Transfer scoreboard and stall-hold checker, sampled mid-cycle.
    initial begin : monitor
        logic        prevStall;
        logic [31:0] prevData;
        logic        prevLast;
        logic [32:0] want;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("hold_valid", out_valid, 1);
                    checkOutput("hold_data", out_data, prevData);
                    checkOutput("hold_last", out_last, prevLast);
                end
                if (frame_done) frameDoneCnt++;
                if (out_valid && out_ready) begin
                    checkOutput("xfer_expected", expQ.size() != 0, 1);
                    if (expQ.size() != 0) begin
                        want = expQ.pop_front();
                        checkOutput("xfer_data", out_data, want[31:0]);
                        checkOutput("xfer_last", out_last, want[32]);
                    end
                end
                prevStall = out_valid && !out_ready;
                prevData  = out_data;
                prevLast  = out_last;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        // Reset state
        applyReset("reset");

        // Single word: written at edge N, visible at edge N+2
        expQ.push_back({1'b0, 32'hA5A5A5A5});
        applyStimulus(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("lat_n", out_valid, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("lat_n1", out_valid, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("lat_n2_valid", out_valid, 1);
        checkOutput("lat_n2_data", out_data, 32'hA5A5A5A5);
        checkOutput("lat_n2_last", out_last, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("single_done_valid", out_valid, 0);
        checkOutput("single_q_empty", expQ.size(), 0);

        // Full frame at line rate
        applyReset("reset2");
        for (int i = 0; i < 2304; i++) begin
            expQ.push_back({(i == 2303), 32'h1000_0000 + 32'(i)});
            applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
        end
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("frame_q_empty", expQ.size(), 0);
        checkOutput("frame_done_cnt", frameDoneCnt, 1);
        checkOutput("frame_overflow", overflow, 0);
`ifdef HW_ACCEL_STREAM_BUFFER_STATS_EN
        checkOutput("frame_count", frame_count, 1);
`endif

        // Backpressure: 600 words with no ready, only the first 512 survive
        applyReset("reset3");
        for (int i = 0; i < 600; i++) begin
            if (i < 512) expQ.push_back({1'b0, 32'h2000_0000 + 32'(i)});
            applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
            if (i == 512) checkOutput("bp_no_ovf_at_full", overflow, 0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bp_overflow", overflow, 1);
`ifdef HW_ACCEL_STREAM_BUFFER_STATS_EN
        checkOutput("bp_drop_count", drop_count, 88);
`endif
        repeat (530) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_q_empty", expQ.size(), 0);
        checkOutput("bp_overflow_sticky", overflow, 1);

        // Stall: ready toggling every cycle
        applyReset("reset4");
        for (int i = 0; i < 40; i++) begin
            expQ.push_back({1'b0, 32'h4000_0000 + 32'(i)});
            applyStimulus(1'b1, 32'h4000_0000 + 32'(i), (i % 2) == 0, 1'b0);
        end
        for (int i = 0; i < 80; i++) applyStimulus(1'b0, 32'h0, (i % 2) == 0, 1'b0);
        checkOutput("stall_q_empty", expQ.size(), 0);

        // Mid-frame reset at word 1000, then a clean frame
        applyReset("reset5");
        for (int i = 0; i < 1000; i++) begin
            expQ.push_back({1'b0, 32'h3000_0000 + 32'(i)});
            applyStimulus(1'b1, 32'h3000_0000 + 32'(i), 1'b1, 1'b0);
        end
        applyReset("midreset");
        for (int i = 0; i < 2304; i++) begin
            expQ.push_back({(i == 2303), 32'h5000_0000 + 32'(i)});
            applyStimulus(1'b1, 32'h5000_0000 + 32'(i), 1'b1, 1'b0);
        end
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("mid_q_empty", expQ.size(), 0);
        checkOutput("mid_frame_done_cnt", frameDoneCnt, 1);

        // Clear priority over a same-cycle drop
        applyReset("reset6");
        for (int i = 0; i < 512; i++) begin
            expQ.push_back({1'b0, 32'h6000_0000 + 32'(i)});
            applyStimulus(1'b1, 32'h6000_0000 + 32'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h6000_0200, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("clr_priority", overflow, 0);
        applyStimulus(1'b1, 32'h6000_0201, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("clr_reset_again", overflow, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("clr_alone", overflow, 0);
        repeat (530) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("clr_q_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
